// File: rtl/in_port_scheduler_pkg.sv
// Shared types and build-time defaults for the input-port scheduler.
// Macro values come from generate_parameter.vh when present; fallbacks keep the slice standalone.
`ifndef PORT_NUM
`define PORT_NUM 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef DATA_LENGTH_MAX
`define DATA_LENGTH_MAX 16
`endif

package in_port_scheduler_pkg;

   localparam int DEF_PORT_NUM     = `PORT_NUM;
   localparam int DEF_DATA_WIDTH   = `DATA_WIDTH;
   localparam int DEF_WIDTH_LENGTH = $clog2(`DATA_LENGTH_MAX);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEAD    = 2'd1,
      ST_READ    = 2'd2,
      ST_RELEASE = 2'd3
   } sched_state_t;

   // Modulo increment used to advance the round-robin pointer past the served port.
   function automatic int wrap_inc(input int value, input int modulus);
      return (value + 1 >= modulus) ? 0 : value + 1;
   endfunction

endpackage

// File: rtl/in_port_scheduler_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to 0.
module rr_priority_picker #(
   parameter int PORT_NUM = 4,
   parameter int IDX_W    = 2
) (
   input  logic [PORT_NUM-1:0] req,
   input  logic [IDX_W-1:0]    ptr,
   output logic                any,
   output logic [IDX_W-1:0]    idx
);

   logic [PORT_NUM-1:0] rot;
   logic [IDX_W:0]      sum;

   // Rotate so bit 0 is the port at ptr; the lowest set bit then wins.
   assign rot = PORT_NUM'({req, req} >> ptr);

   always_comb begin
      any = |rot;
      sum = '0;
      for (int j = PORT_NUM - 1; j >= 0; j--) begin
         if (rot[j]) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(j);
         end
      end
      if (sum >= (IDX_W+1)'(PORT_NUM)) begin
         idx = IDX_W'(sum - (IDX_W+1)'(PORT_NUM));
      end else begin
         idx = sum[IDX_W-1:0];
      end
   end

endmodule

// File: rtl/in_port_scheduler.sv
// Moves completed packets from per-port input FIFOs into the shared cache write port,
// one packet at a time: header beat (control word), len data beats, then a ready pulse.
module in_port_scheduler
   import in_port_scheduler_pkg::*;
#(
   parameter  int PORT_NUM     = DEF_PORT_NUM,
   parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter  int WIDTH_LENGTH = DEF_WIDTH_LENGTH,
   localparam int IDX_W        = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [PORT_NUM-1:0]            port_done,
   input  logic [PORT_NUM*DATA_WIDTH-1:0] port_ctrl_data,
   output logic [PORT_NUM-1:0]            port_ready,
   output logic [PORT_NUM-1:0]            fifo_rd_en,
   input  logic [PORT_NUM*DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                           cache_space_ok,
   output logic                           cache_wr_valid,
   output logic [DATA_WIDTH-1:0]          cache_wr_data,
   output logic                           cache_sop,
   output logic                           cache_eop,
   output logic [IDX_W-1:0]               cache_wr_port
);

   localparam logic [WIDTH_LENGTH-1:0] LEN_ONE = WIDTH_LENGTH'(1);

   sched_state_t            state, state_nxt;
   logic [IDX_W-1:0]        rr_ptr;
   logic [IDX_W-1:0]        grant_id;
   logic [IDX_W-1:0]        pick_idx;
   logic                    pick_any;
   logic                    start;
   logic                    rd_now;
   logic                    last_rd;
   logic [WIDTH_LENGTH-1:0] len;
   logic [WIDTH_LENGTH-1:0] cnt;
   logic                    rd_en_d;
   logic                    last_d;
   logic [DATA_WIDTH-1:0]   ctrl_sel;
   logic [DATA_WIDTH-1:0]   fifo_sel;

   rr_priority_picker #(
      .PORT_NUM (PORT_NUM),
      .IDX_W    (IDX_W)
   ) u_picker (
      .req (port_done),
      .ptr (rr_ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign ctrl_sel = port_ctrl_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
   assign fifo_sel = fifo_rd_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
   assign start    = (state == ST_IDLE) && pick_any && cache_space_ok;
   assign rd_now   = (state == ST_READ);
   // len is nonzero whenever READ is entered, so len-1 never wraps here.
   assign last_rd  = (cnt == len - LEN_ONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         cnt      <= '0;
         rd_en_d  <= 1'b0;
         last_d   <= 1'b0;
      end else begin
         state   <= state_nxt;
         rd_en_d <= rd_now;
         last_d  <= rd_now && last_rd;
         case (state)
            ST_IDLE:    if (start) grant_id <= pick_idx;
            ST_HEAD:    cnt <= '0;
            ST_READ:    cnt <= cnt + LEN_ONE;
            ST_RELEASE: rr_ptr <= IDX_W'(wrap_inc(int'(grant_id), PORT_NUM));
            default:    ;
         endcase
      end
   end

   // Packet length is datapath state: only meaningful after a grant loads it.
   always_ff @(posedge clk) begin
      if (start) begin
         len <= port_ctrl_data[pick_idx*DATA_WIDTH +: WIDTH_LENGTH];
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (start) state_nxt = ST_HEAD;
         ST_HEAD:    state_nxt = (len != '0) ? ST_READ : ST_RELEASE;
         ST_READ:    if (last_rd) state_nxt = ST_RELEASE;
         ST_RELEASE: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      fifo_rd_en     = '0;
      port_ready     = '0;
      cache_wr_valid = 1'b0;
      cache_wr_data  = '0;
      cache_sop      = 1'b0;
      cache_eop      = 1'b0;
      cache_wr_port  = '0;
      if (rd_now) begin
         fifo_rd_en[grant_id] = 1'b1;
      end
      if (state == ST_RELEASE) begin
         port_ready[grant_id] = 1'b1;
      end
      // Header and data beats never coincide: rd_en_d is low throughout HEAD.
      if (state == ST_HEAD) begin
         cache_wr_valid = 1'b1;
         cache_sop      = 1'b1;
         cache_eop      = (len == '0);
         cache_wr_data  = ctrl_sel;
      end else if (rd_en_d) begin
         cache_wr_valid = 1'b1;
         cache_eop      = last_d;
         cache_wr_data  = fifo_sel;
      end
      if (cache_wr_valid) begin
         cache_wr_port = grant_id;
      end
   end

endmodule

// File: tb/tb_in_port_scheduler.sv
// Directed bench for in_port_scheduler with a small per-port done/FIFO stimulus model.
module tb_in_port_scheduler;
   import in_port_scheduler_pkg::*;

   localparam int NP = DEF_PORT_NUM;
   localparam int DW = DEF_DATA_WIDTH;

   logic               clk = 1'b0;
   logic               rst;
   logic [NP-1:0]      port_done;
   logic [NP*DW-1:0]   port_ctrl_data;
   logic [NP-1:0]      port_ready;
   logic [NP-1:0]      fifo_rd_en;
   logic [NP*DW-1:0]   fifo_rd_data;
   logic               cache_space_ok;
   logic               cache_wr_valid;
   logic [DW-1:0]      cache_wr_data;
   logic               cache_sop;
   logic               cache_eop;
   logic [1:0]         cache_wr_port;

   logic [DW-1:0]      ctrl [NP];
   logic [NP-1:0]      set_req;
   int                 rd_cnt [NP];
   int                 exp_cnt [NP];
   int                 nvec = 0;
   int                 nerr = 0;

   in_port_scheduler dut (
      .clk            (clk),
      .rst            (rst),
      .port_done      (port_done),
      .port_ctrl_data (port_ctrl_data),
      .port_ready     (port_ready),
      .fifo_rd_en     (fifo_rd_en),
      .fifo_rd_data   (fifo_rd_data),
      .cache_space_ok (cache_space_ok),
      .cache_wr_valid (cache_wr_valid),
      .cache_wr_data  (cache_wr_data),
      .cache_sop      (cache_sop),
      .cache_eop      (cache_eop),
      .cache_wr_port  (cache_wr_port)
   );

   always #5 clk = ~clk;

   assign port_ctrl_data = {ctrl[3], ctrl[2], ctrl[1], ctrl[0]};

   function automatic logic [31:0] fword(input int p, input int k);
      return 32'hF000_0000 | (32'(p) << 16) | 32'(k);
   endfunction

   function automatic logic [31:0] mk(input int p, input int len);
      return {16'hC0DE, 8'(p), 8'(len)};
   endfunction

   // Input controllers: done held until the ready pulse clears it.
   always @(posedge clk) begin
      if (rst) port_done <= '0;
      else     port_done <= (port_done | set_req) & ~port_ready;
   end

   // Port FIFOs: word k of port p is fword(p,k), one cycle after rd_en.
   always @(posedge clk) begin
      for (int p = 0; p < NP; p++) begin
         if (rst) begin
            rd_cnt[p] <= 0;
         end else if (fifo_rd_en[p]) begin
            fifo_rd_data[p*DW +: DW] <= fword(p, rd_cnt[p]);
            rd_cnt[p] <= rd_cnt[p] + 1;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic raise(input logic [NP-1:0] mask);
      set_req = mask;
      cyc();
      set_req = '0;
   endtask

   task automatic chk_quiet(input string tag);
      chk(tag, {cache_wr_valid, cache_sop, cache_eop, 4'(fifo_rd_en), 4'(port_ready), 2'(cache_wr_port)}, 0);
      chk({tag, "_data"}, cache_wr_data, 0);
   endtask

   task automatic expect_packet(input int port, input int len, input int max_wait, input bit drop_space);
      int w;
      logic [31:0] oh;
      oh = 32'(1) << port;
      w  = 0;
      while (cache_wr_valid !== 1'b1 && w < max_wait) begin
         cyc();
         w++;
      end
      chk("hdr_valid", 32'(cache_wr_valid), 1);
      if (cache_wr_valid !== 1'b1) return;
      chk("hdr_sop",  32'(cache_sop), 1);
      chk("hdr_eop",  32'(cache_eop), 32'(len == 0));
      chk("hdr_data", cache_wr_data, ctrl[port]);
      chk("hdr_port", 32'(cache_wr_port), 32'(port));
      chk("hdr_rden", 32'(fifo_rd_en), 0);
      if (drop_space) cache_space_ok = 1'b0;
      cyc();
      if (len == 0) begin
         chk("z_valid", 32'(cache_wr_valid), 0);
         chk("z_rden",  32'(fifo_rd_en), 0);
         chk("z_ready", 32'(port_ready), oh);
      end else begin
         chk("rd0_valid", 32'(cache_wr_valid), 0);
         chk("rd0_rden",  32'(fifo_rd_en), oh);
         for (int k = 0; k < len; k++) begin
            cyc();
            chk("beat_valid", 32'(cache_wr_valid), 1);
            chk("beat_sop",   32'(cache_sop), 0);
            chk("beat_eop",   32'(cache_eop), 32'(k == len - 1));
            chk("beat_data",  cache_wr_data, fword(port, exp_cnt[port]));
            chk("beat_port",  32'(cache_wr_port), 32'(port));
            chk("beat_rden",  32'(fifo_rd_en), (k == len - 1) ? 0 : oh);
            chk("beat_ready", 32'(port_ready), (k == len - 1) ? oh : 0);
            exp_cnt[port]++;
         end
      end
      cyc();
      chk("idle_valid", 32'(cache_wr_valid), 0);
      chk("idle_ready", 32'(port_ready), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      cache_space_ok = 1'b1;
      set_req = '0;
      for (int p = 0; p < NP; p++) begin
         ctrl[p]    = '0;
         exp_cnt[p] = 0;
      end
      cyc(); cyc(); cyc();
      chk_quiet("rst_out");
      rst = 1'b0;
      cyc();
      chk_quiet("post_rst_out");

      // Round-robin from rr_ptr=0, then re-raise 0 and 3.
      for (int p = 0; p < NP; p++) ctrl[p] = mk(p, 2);
      raise(4'b1111);
      for (int p = 0; p < NP; p++) expect_packet(p, 2, 1, 1'b0);
      raise(4'b1001);
      expect_packet(0, 2, 1, 1'b0);
      expect_packet(3, 2, 1, 1'b0);

      // Single packet, port 1, len 3.
      ctrl[1] = mk(1, 3);
      raise(4'b0010);
      expect_packet(1, 3, 1, 1'b0);

      // Fairness: port 2 keeps re-requesting while port 3 waits.
      ctrl[2] = mk(2, 1);
      ctrl[3] = mk(3, 1);
      set_req = 4'b1100;
      cyc();
      set_req = 4'b0100;
      expect_packet(2, 1, 1, 1'b0);
      expect_packet(3, 1, 1, 1'b0);
      set_req = '0;
      expect_packet(2, 1, 1, 1'b0);

      // Zero length.
      ctrl[0] = mk(0, 0);
      raise(4'b0001);
      expect_packet(0, 0, 1, 1'b0);

      // Space backpressure, then space dropped mid-packet.
      cache_space_ok = 1'b0;
      ctrl[0] = mk(0, 2);
      raise(4'b0001);
      for (int i = 0; i < 10; i++) begin
         chk_quiet("bp_quiet");
         cyc();
      end
      cache_space_ok = 1'b1;
      expect_packet(0, 2, 1, 1'b0);
      ctrl[0] = mk(0, 4);
      raise(4'b0001);
      expect_packet(0, 4, 1, 1'b1);
      cache_space_ok = 1'b1;

      // Reset after three reads of a len=8 packet on port 1.
      ctrl[1] = mk(1, 8);
      raise(4'b0010);
      cyc();
      chk("rst_hdr", {31'd0, cache_sop}, 1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("rst_rden", 32'(fifo_rd_en), 32'b0010);
      end
      rst = 1'b1;
      cyc();
      chk_quiet("mid_rst_out");
      rst = 1'b0;
      for (int p = 0; p < NP; p++) exp_cnt[p] = 0;
      cyc();
      chk_quiet("after_rst_out");
      ctrl[0] = mk(0, 2);
      ctrl[1] = mk(1, 2);
      raise(4'b0011);
      expect_packet(0, 2, 1, 1'b0);
      expect_packet(1, 2, 1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
